// File: rtl/vector_sequencer.sv
// vector_sequencer: clocked stimulus controller for one combinational block.
// Vectors {inputs, expected} live in an internal RAM and are applied one at a
// time. After a fixed settle time the block's response is compared with the
// expected field, and the run stops at the first mismatch.
//
// Handshake: a start pulse is taken only while the FSM sits in IDLE. busy is
// high from the cycle after the accepted start up to, but not including, the
// one-cycle done pulse. RAM writes are taken on any cycle with wr_en high
// while busy is low.
module vector_sequencer #(
    parameter int IW     = 3,
    parameter int OW     = 1,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int VW    = IW + OW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [VW-1:0] i_wr_data,
    input  logic [AW:0]   i_num_vec,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic          o_fail,
    output logic [AW-1:0] o_fail_idx,
    output logic [OW-1:0] o_fail_got,
    output logic [OW-1:0] o_fail_exp,
    output logic [AW:0]   o_pass_cnt,
    output logic [IW-1:0] o_dut_in,
    input  logic [OW-1:0] i_dut_out,
    output logic [2:0]    o_state
);

    // The settle counter is at least one bit wide, even for SETTLE == 1.
    localparam int           SCW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE - 1);
    localparam logic [AW:0]  L_DEPTH = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [VW-1:0] r_mem [DEPTH];
    logic [VW-1:0] r_rd_data;
    logic [AW-1:0] w_rd_addr;

    logic [AW-1:0]  r_vn;
    logic [AW:0]    r_n;
    logic [SCW-1:0] r_scnt;
    logic [OW-1:0]  r_exp;
    logic [IW-1:0]  r_dut_in;
    logic           r_pass;
    logic           r_fail;
    logic [AW-1:0]  r_fail_idx;
    logic [OW-1:0]  r_fail_got;
    logic [OW-1:0]  r_fail_exp;
    logic [AW:0]    r_pass_cnt;

    logic [AW:0]    w_n_clamp;
    logic           w_mismatch;
    logic           w_last;
    logic           w_busy;
    logic           w_done;

    // Requested vector count, limited to the RAM depth.
    assign w_n_clamp  = (i_num_vec > L_DEPTH) ? L_DEPTH : i_num_vec;
    // Case inequality: an X or Z on the block output counts as a mismatch.
    assign w_mismatch = (i_dut_out !== r_exp);
    assign w_last     = ({1'b0, r_vn} == (r_n - (AW + 1)'(1)));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, status strobes and RAM read address.
    always_comb begin
        w_next_state = r_state;
        w_rd_addr    = r_vn;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_n_clamp == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_FETCH;
                        w_rd_addr    = '0;
                    end
                end
            end
            S_FETCH: begin
                w_busy       = 1'b1;
                w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                w_busy = 1'b1;
                if (r_scnt == SC_LAST) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_busy = 1'b1;
                if (w_mismatch || w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FETCH;
                    w_rd_addr    = r_vn + AW'(1);
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Vector RAM: synchronous write when idle, registered read.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !w_busy) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Run datapath: vector index, stimulus, settle counter and result flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vn       <= '0;
            r_n        <= '0;
            r_scnt     <= '0;
            r_exp      <= '0;
            r_dut_in   <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
            r_fail_got <= '0;
            r_fail_exp <= '0;
            r_pass_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pass     <= (w_n_clamp == '0);
                        r_fail     <= 1'b0;
                        r_pass_cnt <= '0;
                        r_vn       <= '0;
                        r_n        <= w_n_clamp;
                    end
                end
                S_FETCH: begin
                    r_dut_in <= r_rd_data[VW-1:OW];
                    r_exp    <= r_rd_data[OW-1:0];
                    r_scnt   <= '0;
                end
                S_SETTLE: begin
                    r_scnt <= r_scnt + SCW'(1);
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_fail     <= 1'b1;
                        r_fail_idx <= r_vn;
                        r_fail_got <= i_dut_out;
                        r_fail_exp <= r_exp;
                    end else begin
                        r_pass_cnt <= r_pass_cnt + (AW + 1)'(1);
                        if (w_last) begin
                            r_pass <= 1'b1;
                        end else begin
                            r_vn <= r_vn + AW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_fail_idx = r_fail_idx;
    assign o_fail_got = r_fail_got;
    assign o_fail_exp = r_fail_exp;
    assign o_pass_cnt = r_pass_cnt;
    assign o_dut_in   = r_dut_in;
    assign o_state    = r_state;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer driving a 3-input XOR as the block under test.
module tb_vector_sequencer;

  localparam int IW     = 3;
  localparam int OW     = 1;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 2;
  localparam int AW     = 3;
  localparam int VW     = IW + OW;
  localparam int PER    = SETTLE + 2;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic [AW:0]   num_vec;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic [AW-1:0] fail_idx;
  logic [OW-1:0] fail_got;
  logic [OW-1:0] fail_exp;
  logic [AW:0]   pass_cnt;
  logic [IW-1:0] dut_in;
  logic [OW-1:0] dut_out;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] exp_q[$];
  logic [VW-1:0] golden[DEPTH];

  // Block under test: 3-input XOR.
  assign dut_out = ^dut_in;

  vector_sequencer #(
    .IW(IW), .OW(OW), .DEPTH(DEPTH), .SETTLE(SETTLE)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_num_vec  (num_vec),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_fail     (fail),
    .o_fail_idx (fail_idx),
    .o_fail_got (fail_got),
    .o_fail_exp (fail_exp),
    .o_pass_cnt (pass_cnt),
    .o_dut_in   (dut_in),
    .i_dut_out  (dut_out),
    .o_state    (state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_vec(input logic [AW-1:0] a, input logic [VW-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic load_xor();
    for (int a = 0; a < DEPTH; a++) begin
      logic [IW-1:0] v;
      v = IW'(a);
      golden[a] = {v, ^v};
      write_vec(AW'(a), golden[a]);
    end
  endtask

  // Scoreboard: stimulus expected on dut_in for the first cnt vectors.
  task automatic push_vecs(input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back(golden[k][VW-1:OW]);
  endtask

  // Start a run and observe win cycles after the accepting edge (cycle 1..win).
  // Optional mid-run start pulse / RAM write in cycle start_at / wr_at.
  task automatic run(input int num, input int win, input int start_at,
                     input int wr_at, input logic [AW-1:0] wa, input logic [VW-1:0] wd,
                     output int done_cyc, output int done_cnt,
                     output int busy_first, output int busy_last, output int busy_cnt);
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    @(negedge clk);
    num_vec = (AW + 1)'(num);
    start   = 1'b1;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (pass && fail) check("pass_fail_excl", {pass, fail}, 2'b00);
      if ((c % PER) == 0 && exp_q.size() != 0) check("sb_dut_in", dut_in, exp_q.pop_front());
      start   = (c == start_at);
      wr_en   = (c == wr_at);
      wr_addr = wa;
      wr_data = wd;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("sb_drain", exp_q.size(), 0);
  endtask

  int dc, dn, bf, bl, bn;

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    num_vec = '0;
    start   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_fail_idx", fail_idx, 0);
    reset = 1'b0;

    load_xor();

    // Full XOR table passes.
    push_vecs(8);
    run(8, 36, -1, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t1_done_cyc", dc, 33);
    check("t1_done_cnt", dn, 1);
    check("t1_busy_first", bf, 1);
    check("t1_busy_last", bl, 32);
    check("t1_busy_cnt", bn, 32);
    check("t1_pass", pass, 1);
    check("t1_fail", fail, 0);
    check("t1_pass_cnt", pass_cnt, 8);
    check("t1_dut_in", dut_in, 3'b111);

    // Vector 5 expected bit inverted: stop at 5.
    golden[5] = {3'b101, 1'b1};
    write_vec(3'd5, golden[5]);
    push_vecs(6);
    run(8, 30, -1, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t2_done_cyc", dc, 25);
    check("t2_done_cnt", dn, 1);
    check("t2_busy_last", bl, 24);
    check("t2_fail", fail, 1);
    check("t2_pass", pass, 0);
    check("t2_fail_idx", fail_idx, 5);
    check("t2_fail_got", fail_got, 0);
    check("t2_fail_exp", fail_exp, 1);
    check("t2_pass_cnt", pass_cnt, 5);
    check("t2_dut_in", dut_in, 3'b101);
    golden[5] = {3'b101, 1'b0};
    write_vec(3'd5, golden[5]);

    // Zero-length run.
    run(0, 6, -1, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t3_done_cyc", dc, 1);
    check("t3_done_cnt", dn, 1);
    check("t3_busy_cnt", bn, 0);
    check("t3_pass", pass, 1);
    check("t3_fail", fail, 0);
    check("t3_pass_cnt", pass_cnt, 0);
    check("t3_dut_in", dut_in, 3'b101);

    // Mid-run start and RAM write are ignored.
    push_vecs(8);
    run(8, 36, 6, 9, 3'd2, 4'b1111, dc, dn, bf, bl, bn);
    check("t4_done_cyc", dc, 33);
    check("t4_done_cnt", dn, 1);
    check("t4_pass", pass, 1);
    push_vecs(8);
    run(8, 36, -1, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t4r_done_cyc", dc, 33);
    check("t4r_pass", pass, 1);
    check("t4r_pass_cnt", pass_cnt, 8);

    // Reset in cycle 10 of a run.
    @(negedge clk);
    num_vec = 4'd8;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_busy_c10", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_dut_in", dut_in, 0);
    check("t5_pass_cnt", pass_cnt, 0);
    check("t5_pass", pass, 0);
    reset = 1'b0;
    push_vecs(8);
    run(8, 36, -1, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t5r_done_cyc", dc, 33);
    check("t5r_pass", pass, 1);

    // num_vec above depth is clamped; start during DONE is ignored.
    push_vecs(8);
    run(12, 40, 33, -1, '0, '0, dc, dn, bf, bl, bn);
    check("t6_done_cyc", dc, 33);
    check("t6_done_cnt", dn, 1);
    check("t6_busy_cnt", bn, 32);
    check("t6_pass", pass, 1);
    check("t6_pass_cnt", pass_cnt, 8);

    // Random-length runs on the intact table.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      push_vecs(n);
      run(n, n * PER + 4, -1, -1, '0, '0, dc, dn, bf, bl, bn);
      check("rnd_done_cyc", dc, n * PER + 1);
      check("rnd_pass_cnt", pass_cnt, n);
      check("rnd_dut_in", dut_in, golden[n-1][VW-1:OW]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Synthesizable self-checking stimulus controller for one combinational block under test (xor/and/gate/mux style).
- Holds packed test vectors {inputs, expected} in an internal RAM and applies them one by one to the DUT.
- Waits a programmable settle time, compares the DUT output against the expected value and stops on the first mismatch.
- Replaces delay-driven simulation loops with a clocked, reusable sequencer that can also run on hardware.

Parameters:
IW, 3, DUT input width in bits (>=1)
OW, 1, DUT output width in bits (>=1)
DEPTH, 8, vector RAM depth (power of 2, >=2); AW = $clog2(DEPTH)
SETTLE, 2, cycles to wait after applying a vector before compare (>=1)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
wr_en  in  1  vector RAM write strobe; ignored while busy=1
wr_addr  in  AW  RAM write address
wr_data  in  IW+OW  packed vector {inputs[IW+OW-1:OW], expected[OW-1:0]}
num_vec  in  AW+1  number of vectors to run; sampled on accepted start
start  in  1  run request; accepted only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse at end of run
pass  out  1  1 = all run vectors matched; held until next accepted start
fail  out  1  1 = mismatch stopped the run; held until next accepted start
fail_idx  out  AW  index of the failing vector
fail_got  out  OW  DUT output captured at the failing compare
fail_exp  out  OW  expected value of the failing vector
pass_cnt  out  AW+1  number of vectors that matched in the current/last run
dut_in  out  IW  registered stimulus to the DUT
dut_out  in  OW  DUT response

Behaviour:
- Reset: state IDLE; every output is 0; vn=0. RAM contents are not cleared.
- RAM: write is synchronous on wr_en && !busy. Read is synchronous with 1-cycle latency.
- Start: num_vec is clamped to DEPTH when larger; the clamped value is n.
- States: IDLE, FETCH, SETTLE, CHECK, DONE.
- IDLE: busy=0. On start:
  - pass, fail and pass_cnt are cleared and vn=0.
  - n==0 goes directly to DONE with pass=1.
  - Otherwise RAM address 0 is issued and the FSM moves to FETCH.
- FETCH (1 cycle): registers dut_in <= inputs field and exp_q <= expected field. Goes to SETTLE with scnt=0.
- SETTLE (exactly SETTLE cycles): scnt increments. When scnt==SETTLE-1 the FSM moves to CHECK.
- CHECK (1 cycle): compares dut_out against exp_q using case-inequality, so any X/Z bit counts as a mismatch in simulation.
  - Mismatch: fail=1, fail_idx=vn, fail_got=dut_out, fail_exp=exp_q, go to DONE.
  - Match with vn==n-1: pass_cnt increments, pass=1, go to DONE.
  - Match otherwise: pass_cnt increments, vn increments, the next RAM address is issued, go to FETCH.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing: let E0 be the edge that accepts start. Vector k occupies cycles k*(SETTLE+2)+1 .. (k+1)*(SETTLE+2).
  - Full pass: done is high in cycle n*(SETTLE+2)+1.
  - Failure at vector k: done is high in cycle (k+1)*(SETTLE+2)+1.
  - n==0: done is high in cycle 1.
- dut_in holds the last applied vector after the run ends.
- start while not IDLE is ignored. start asserted in the same cycle as DONE is ignored; it is accepted only from IDLE.
- Reset mid-run: the FSM returns to IDLE at the next edge and all outputs are zeroed. No done pulse is produced.
- pass and fail are never 1 simultaneously.

Test Plan:
- Load the 8-vector 3-input XOR truth table (e.g. 011_0, 111_1), num_vec=8, SETTLE=2, start -> busy=1 in cycles 1..32, done only in cycle 33, pass=1, fail=0, pass_cnt=8.
- Same table with the expected bit of vector 5 inverted -> done in cycle 25, fail=1, pass=0, fail_idx=5, fail_got=0, fail_exp=1, pass_cnt=5, dut_in=3'b101.
- num_vec=0, start -> done in cycle 1, pass=1, pass_cnt=0, busy never high, dut_in unchanged.
- During a run, pulse start and write addr 2 with 4'b1111 -> run timing unchanged (done in cycle 33). Re-running afterwards passes, proving the RAM was not written.
- Assert reset in cycle 10 of a run -> next cycle busy=0, done=0, dut_in=0, pass_cnt=0. A fresh start then completes with pass=1 in cycle 33.
- num_vec=12 with DEPTH=8 -> clamped, done in cycle 33, pass=1, pass_cnt=8.
